// File: rtl/ahb_lite_slv_sif_pkg.sv
// Shared definitions for the AHB-Lite subordinate front end.
//   - htrans transfer-type encodings
//   - hsize transfer-size encodings
//   - data-phase state type (idle, data phase, second error cycle)
package ahb_lite_slv_sif_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_8   = 3'd0;
    localparam logic [2:0] HSIZE_16  = 3'd1;
    localparam logic [2:0] HSIZE_32  = 3'd2;
    localparam logic [2:0] HSIZE_64  = 3'd3;
    localparam logic [2:0] HSIZE_128 = 3'd4;
    localparam logic [2:0] HSIZE_256 = 3'd5;

    typedef enum logic [1:0] {
        DP_IDLE = 2'd0,
        DP_DATA = 2'd1,
        DP_ERR2 = 2'd2
    } dphase_e;

endpackage

// File: rtl/ahb_lite_slv_sif.sv
// AHB-Lite subordinate front end: turns AHB-Lite address/data-phase transfers
// into a single-request client interface (dv/hld/err handshake).
// Ports:
//   hclk, hreset_n            clock, async active-low reset
//   haddr_i/hsize_i/htrans_i/hwrite_i/hsel_i/hready_i   AHB address phase
//   hwdata_i                  AHB write data (data phase)
//   hrdata_o/hresp_o/hreadyout_o  AHB response
//   dv/write/addr/wdata       client request (valid for the whole data phase)
//   hld/err/rdata             client stall, error and read data
module ahb_lite_slv_sif
    import ahb_lite_slv_sif_pkg::*;
#(
    parameter int AHB_ADDR_WIDTH    = 32,
    parameter int AHB_DATA_WIDTH    = 64,
    parameter int CLIENT_DATA_WIDTH = 32
) (
    input  logic                         hclk,
    input  logic                         hreset_n,
    input  logic [AHB_ADDR_WIDTH-1:0]    haddr_i,
    input  logic [2:0]                   hsize_i,
    input  logic [1:0]                   htrans_i,
    input  logic [AHB_DATA_WIDTH-1:0]    hwdata_i,
    input  logic                         hwrite_i,
    input  logic                         hsel_i,
    input  logic                         hready_i,
    output logic [AHB_DATA_WIDTH-1:0]    hrdata_o,
    output logic                         hresp_o,
    output logic                         hreadyout_o,
    output logic                         dv,
    input  logic                         hld,
    input  logic                         err,
    output logic                         write,
    output logic [CLIENT_DATA_WIDTH-1:0] wdata,
    output logic [AHB_ADDR_WIDTH-1:0]    addr,
    input  logic [CLIENT_DATA_WIDTH-1:0] rdata
);

    localparam int         LANES    = AHB_DATA_WIDTH / CLIENT_DATA_WIDTH;
    localparam int         LANE_LSB = $clog2(CLIENT_DATA_WIDTH / 8);
    localparam logic [2:0] SIZE_MAX = 3'(LANE_LSB);

    dphase_e                   state, state_nxt;
    logic [AHB_ADDR_WIDTH-1:0] addr_q;
    logic                      write_q;
    logic                      size_err_q;
    logic                      accept, complete, take;
    logic [AHB_ADDR_WIDTH-1:0] lane_idx;

    assign accept = hsel_i & hready_i &
                    ((htrans_i == HTRANS_NONSEQ) | (htrans_i == HTRANS_SEQ));

    // A size-errored transfer occupies a data phase slot but never shows dv;
    // that slot is the first error cycle.
    assign dv       = (state == DP_DATA) & ~size_err_q;
    assign complete = dv & ~hld & ~err;

    // While a data phase is still open the address phase may only be taken
    // in its completing cycle.
    assign take = accept & ((state != DP_DATA) | complete);

    assign hreadyout_o = (state == DP_DATA) ? complete : 1'b1;
    assign hresp_o     = ((state == DP_DATA) & (size_err_q | err)) | (state == DP_ERR2);
    assign write       = write_q;
    assign addr        = addr_q;

    always_comb begin
        state_nxt = DP_IDLE;
        case (state)
            DP_IDLE: state_nxt = take ? DP_DATA : DP_IDLE;
            DP_DATA: begin
                if (size_err_q | err) state_nxt = DP_ERR2;   // err beats hld
                else if (hld)         state_nxt = DP_DATA;
                else                  state_nxt = take ? DP_DATA : DP_IDLE;
            end
            DP_ERR2: state_nxt = take ? DP_DATA : DP_IDLE;
            default: state_nxt = DP_IDLE;
        endcase
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state      <= DP_IDLE;
            addr_q     <= '0;
            write_q    <= 1'b0;
            size_err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (take) begin
                addr_q     <= haddr_i;
                write_q    <= hwrite_i;
                size_err_q <= (hsize_i > SIZE_MAX);
            end
        end
    end

    // Lane select: address bits above the client word offset, within the AHB
    // bus width. Collapses to 0 when both widths match.
    assign lane_idx = (addr_q >> LANE_LSB) & AHB_ADDR_WIDTH'(LANES - 1);

    always_comb begin
        wdata    = '0;
        hrdata_o = '0;
        for (int l = 0; l < LANES; l++) begin
            if (lane_idx == AHB_ADDR_WIDTH'(l)) begin
                wdata = hwdata_i[l*CLIENT_DATA_WIDTH +: CLIENT_DATA_WIDTH];
                if (dv & ~write_q)
                    hrdata_o[l*CLIENT_DATA_WIDTH +: CLIENT_DATA_WIDTH] = rdata;
            end
        end
    end

endmodule

// File: tb/tb_ahb_lite_slv_sif.sv
module tb_ahb_lite_slv_sif;

    logic        hclk = 1'b0;
    logic        hreset_n;
    logic [31:0] haddr_i;
    logic [2:0]  hsize_i;
    logic [1:0]  htrans_i;
    logic [63:0] hwdata_i;
    logic        hwrite_i, hsel_i, hready_i;
    logic [63:0] hrdata_o;
    logic        hresp_o, hreadyout_o, dv, hld, err, write;
    logic [31:0] wdata, addr, rdata;

    int checks   = 0;
    int failures = 0;

    always #5 hclk = ~hclk;

    ahb_lite_slv_sif #(
        .AHB_ADDR_WIDTH(32), .AHB_DATA_WIDTH(64), .CLIENT_DATA_WIDTH(32)
    ) dut (
        .hclk(hclk), .hreset_n(hreset_n), .haddr_i(haddr_i), .hsize_i(hsize_i),
        .htrans_i(htrans_i), .hwdata_i(hwdata_i), .hwrite_i(hwrite_i),
        .hsel_i(hsel_i), .hready_i(hready_i), .hrdata_o(hrdata_o),
        .hresp_o(hresp_o), .hreadyout_o(hreadyout_o), .dv(dv), .hld(hld),
        .err(err), .write(write), .wdata(wdata), .addr(addr), .rdata(rdata)
    );

    typedef struct {
        logic [1:0]  t;
        logic        sel, rdy, wr;
        logic [31:0] a;
        logic [2:0]  sz;
        logic [63:0] wd;
        logic        hld, err;
        logic [31:0] rd;
        logic        e_dv, e_wr;
        logic [31:0] e_addr, e_wdata;
        logic [63:0] e_hrdata;
        logic        e_resp, e_rdy;
    } vec_t;

    vec_t tbl[15];

    function automatic vec_t mk(logic [1:0] t, logic sel, logic rdy, logic wr,
                                logic [31:0] a, logic [2:0] sz, logic [63:0] wd,
                                logic h, logic e, logic [31:0] rd,
                                logic e_dv, logic e_wr, logic [31:0] e_addr,
                                logic [31:0] e_wdata, logic [63:0] e_hrdata,
                                logic e_resp, logic e_rdy);
        vec_t v;
        v.t = t; v.sel = sel; v.rdy = rdy; v.wr = wr; v.a = a; v.sz = sz;
        v.wd = wd; v.hld = h; v.err = e; v.rd = rd;
        v.e_dv = e_dv; v.e_wr = e_wr; v.e_addr = e_addr; v.e_wdata = e_wdata;
        v.e_hrdata = e_hrdata; v.e_resp = e_resp; v.e_rdy = e_rdy;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] t, input logic sel, input logic rdy,
                         input logic wr, input logic [31:0] a, input logic [2:0] sz,
                         input logic [63:0] wd, input logic h, input logic e,
                         input logic [31:0] rd);
        htrans_i = t; hsel_i = sel; hready_i = rdy; hwrite_i = wr; haddr_i = a;
        hsize_i = sz; hwdata_i = wd; hld = h; err = e; rdata = rd;
    endtask

    task automatic idle_in();
        drive(2'b00, 1'b0, 1'b1, 1'b0, 32'h0, 3'd2, 64'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic next_cycle();
        @(posedge hclk);
        #1;
    endtask

    // Behavioural reference: phase 0 = no transfer, 1 = data phase, 2 = second
    // error cycle. Outputs follow from the bus handshake rules.
    int          m_phase;
    logic [31:0] m_addr;
    logic        m_write, m_bad;
    logic        x_dv, x_resp, x_rdy;
    logic [63:0] x_hrdata;
    logic [31:0] x_wdata;

    task automatic model_outputs();
        int lane;
        lane     = (m_addr % 8) / 4;
        x_dv     = (m_phase == 1) && !m_bad;
        x_resp   = (m_phase == 2) || ((m_phase == 1) && (m_bad || err));
        x_rdy    = (m_phase != 1) || (x_dv && !hld && !err);
        x_hrdata = (x_dv && !m_write) ? (64'(rdata) << (32 * lane)) : 64'h0;
        x_wdata  = 32'(hwdata_i >> (32 * lane));
    endtask

    task automatic model_clock();
        bit acc;
        acc = hsel_i && hready_i && (htrans_i >= 2);
        if (m_phase == 1 && !x_rdy) begin
            if (x_resp) m_phase = 2;
        end else if (acc) begin
            m_phase = 1; m_addr = haddr_i; m_write = hwrite_i; m_bad = (hsize_i > 2);
        end else begin
            m_phase = 0;
        end
    endtask

    initial begin
        hreset_n = 1'b0;
        idle_in();

        tbl[0]  = mk(2'b00,1,1,0,32'h200,2,64'h0,0,0,32'h0,            0,0,32'h0,  32'h0,64'h0,0,1);
        tbl[1]  = mk(2'b10,1,1,1,32'h104,2,64'h0,0,0,32'h0,            0,0,32'h0,  32'h0,64'h0,0,1);
        tbl[2]  = mk(2'b10,1,1,0,32'h100,2,64'hAAAABBBBCCCCDDDD,0,0,32'h0, 1,1,32'h104,32'hAAAABBBB,64'h0,0,1);
        tbl[3]  = mk(2'b10,1,1,0,32'h104,2,64'h0,0,0,32'h12345678,     1,0,32'h100,32'h0,64'h0000000012345678,0,1);
        tbl[4]  = mk(2'b01,1,1,0,32'h300,2,64'h0,0,0,32'h12345678,     1,0,32'h104,32'h0,64'h1234567800000000,0,1);
        tbl[5]  = mk(2'b00,1,1,0,32'h0,  2,64'h0,0,0,32'h0,            0,0,32'h104,32'h0,64'h0,0,1);
        tbl[6]  = mk(2'b10,1,1,1,32'h0,  2,64'h0,0,0,32'h0,            0,0,32'h104,32'h0,64'h0,0,1);
        tbl[7]  = mk(2'b11,1,1,1,32'h4,  2,64'h1111111122222222,0,0,32'h0, 1,1,32'h0,  32'h22222222,64'h0,0,1);
        tbl[8]  = mk(2'b10,0,1,1,32'h8,  2,64'h3333333344444444,0,0,32'h0, 1,1,32'h4,  32'h33333333,64'h0,0,1);
        tbl[9]  = mk(2'b10,1,0,0,32'h10, 2,64'h0,0,0,32'h0,            0,1,32'h4,  32'h0,64'h0,0,1);
        tbl[10] = mk(2'b10,1,1,0,32'h20, 3,64'h0,0,0,32'h0,            0,1,32'h4,  32'h0,64'h0,0,1);
        tbl[11] = mk(2'b00,1,0,0,32'h0,  2,64'h0,0,0,32'h0,            0,0,32'h20, 32'h0,64'h0,1,0);
        tbl[12] = mk(2'b10,1,1,0,32'h8,  2,64'h0,0,0,32'h0,            0,0,32'h20, 32'h0,64'h0,1,1);
        tbl[13] = mk(2'b00,1,1,0,32'h0,  2,64'h0,0,0,32'hCAFEF00D,     1,0,32'h8,  32'h0,64'h00000000CAFEF00D,0,1);
        tbl[14] = mk(2'b00,1,1,0,32'h0,  2,64'h0,0,0,32'h0,            0,0,32'h8,  32'h0,64'h0,0,1);

        // Reset state
        repeat (2) @(posedge hclk);
        #2;
        chk("rst_hreadyout", 64'(hreadyout_o), 64'h1);
        chk("rst_hresp",     64'(hresp_o),     64'h0);
        chk("rst_hrdata",    hrdata_o,         64'h0);
        chk("rst_dv",        64'(dv),          64'h0);
        chk("rst_write",     64'(write),       64'h0);
        chk("rst_addr",      64'(addr),        64'h0);
        next_cycle();
        hreset_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].t, tbl[i].sel, tbl[i].rdy, tbl[i].wr, tbl[i].a, tbl[i].sz,
                  tbl[i].wd, tbl[i].hld, tbl[i].err, tbl[i].rd);
            #4;
            chk($sformatf("tbl%0d_dv", i),     64'(dv),          64'(tbl[i].e_dv));
            chk($sformatf("tbl%0d_hresp", i),  64'(hresp_o),     64'(tbl[i].e_resp));
            chk($sformatf("tbl%0d_hready", i), 64'(hreadyout_o), 64'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_write", i),  64'(write),       64'(tbl[i].e_wr));
            chk($sformatf("tbl%0d_addr", i),   64'(addr),        64'(tbl[i].e_addr));
            chk($sformatf("tbl%0d_hrdata", i), hrdata_o,         tbl[i].e_hrdata);
            if (tbl[i].e_dv)
                chk($sformatf("tbl%0d_wdata", i), 64'(wdata), 64'(tbl[i].e_wdata));
            next_cycle();
        end

        // Stall: three hld cycles then completion
        drive(2'b10, 1, 1, 0, 32'h10C, 2, 64'h0, 0, 0, 32'h0);
        next_cycle();
        for (int s = 0; s < 3; s++) begin
            drive(2'b10, 1, 0, 0, 32'h999, 2, 64'h0, 1, 0, 32'h0);
            #4;
            chk($sformatf("stall%0d_hready", s), 64'(hreadyout_o), 64'h0);
            chk($sformatf("stall%0d_dv", s),     64'(dv),          64'h1);
            chk($sformatf("stall%0d_addr", s),   64'(addr),        64'h10C);
            next_cycle();
        end
        drive(2'b00, 1, 1, 0, 32'h0, 2, 64'h0, 0, 0, 32'hDEADBEEF);
        #4;
        chk("stall_done_hready", 64'(hreadyout_o), 64'h1);
        chk("stall_done_hrdata", hrdata_o,         64'hDEADBEEF00000000);
        next_cycle();
        idle_in();
        #4;
        chk("stall_after_dv", 64'(dv), 64'h0);
        next_cycle();

        // Client error (err together with hld), new accept in error cycle 2
        drive(2'b10, 1, 1, 1, 32'h18, 2, 64'h0, 0, 0, 32'h0);
        next_cycle();
        drive(2'b00, 1, 0, 0, 32'h0, 2, 64'h0, 1, 1, 32'h0);
        #4;
        chk("err1_hresp",  64'(hresp_o),     64'h1);
        chk("err1_hready", 64'(hreadyout_o), 64'h0);
        next_cycle();
        drive(2'b10, 1, 1, 0, 32'h20, 2, 64'h0, 0, 0, 32'h0);
        #4;
        chk("err2_hresp",  64'(hresp_o),     64'h1);
        chk("err2_hready", 64'(hreadyout_o), 64'h1);
        chk("err2_dv",     64'(dv),          64'h0);
        next_cycle();
        drive(2'b00, 1, 1, 0, 32'h0, 2, 64'h0, 0, 0, 32'h55);
        #4;
        chk("err_next_dv",     64'(dv),      64'h1);
        chk("err_next_addr",   64'(addr),    64'h20);
        chk("err_next_hrdata", hrdata_o,     64'h55);
        chk("err_next_hresp",  64'(hresp_o), 64'h0);
        next_cycle();

        // Reset during a stalled transfer
        drive(2'b10, 1, 1, 1, 32'h40, 2, 64'h0, 0, 0, 32'h0);
        next_cycle();
        drive(2'b00, 1, 0, 0, 32'h0, 2, 64'h0, 1, 0, 32'h0);
        #3;
        chk("prerst_hready", 64'(hreadyout_o), 64'h0);
        hreset_n = 1'b0;
        #1;
        chk("midrst_hready", 64'(hreadyout_o), 64'h1);
        chk("midrst_dv",     64'(dv),          64'h0);
        chk("midrst_addr",   64'(addr),        64'h0);
        chk("midrst_write",  64'(write),       64'h0);
        next_cycle();
        hreset_n = 1'b1;
        idle_in();
        #4;
        chk("postrst_dv", 64'(dv), 64'h0);
        next_cycle();

        // Randomized traffic against the reference model
        m_phase = 0; m_addr = 0; m_write = 0; m_bad = 0;
        for (int c = 0; c < 2000; c++) begin
            htrans_i = 2'($urandom_range(0, 3));
            hsel_i   = ($urandom_range(0, 5) != 0);
            hwrite_i = 1'($urandom);
            haddr_i  = $urandom;
            hsize_i  = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            hwdata_i = {$urandom, $urandom};
            rdata    = $urandom;
            hld      = ($urandom_range(0, 9) < 3);
            err      = ($urandom_range(0, 19) == 0);
            model_outputs();
            hready_i = x_rdy;
            #4;
            chk("rnd_dv",     64'(dv),          64'(x_dv));
            chk("rnd_hresp",  64'(hresp_o),     64'(x_resp));
            chk("rnd_hready", 64'(hreadyout_o), 64'(x_rdy));
            chk("rnd_hrdata", hrdata_o,         x_hrdata);
            if (x_dv) begin
                chk("rnd_addr",  64'(addr),  64'(m_addr));
                chk("rnd_write", 64'(write), 64'(m_write));
                chk("rnd_wdata", 64'(wdata), 64'(x_wdata));
            end
            model_clock();
            next_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
